// File: rtl/snake_pkg.sv
// snake_pkg -- shared definitions for the snake direction front-end.
//   Direction codes are one-cold on the core's dir_n bus {E,S,W,N};
//   4'b1111 means stopped. Button indices follow the btn_n pin order.
//   Helpers map a button index to its heading and a heading to its opposite.
package snake_pkg;

  localparam int NUM_BTN = 4;

  localparam int BTN_NORTH = 0;
  localparam int BTN_WEST  = 1;
  localparam int BTN_SOUTH = 2;
  localparam int BTN_EAST  = 3;

  typedef logic [NUM_BTN-1:0] dir_t;

  localparam dir_t DIR_STOP = 4'b1111;
  localparam dir_t DIR_N    = 4'b1110;
  localparam dir_t DIR_W    = 4'b1101;
  localparam dir_t DIR_S    = 4'b1011;
  localparam dir_t DIR_E    = 4'b0111;

  // Heading request produced by the arbiter.
  typedef struct packed {
    logic vld;
    dir_t code;
  } dir_req_t;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_MOVING  = 1'b1
  } dir_state_t;

  function automatic dir_t dir_opposite(input dir_t code);
    case (code)
      DIR_N:   return DIR_S;
      DIR_S:   return DIR_N;
      DIR_W:   return DIR_E;
      DIR_E:   return DIR_W;
      default: return DIR_STOP;
    endcase
  endfunction

  function automatic dir_t dir_from_index(input logic [1:0] idx);
    case (idx)
      2'd0:    return DIR_N;
      2'd1:    return DIR_W;
      2'd2:    return DIR_S;
      default: return DIR_E;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce -- one push-button path: 2-flop synchronizer, counter
// debouncer and a single-cycle press pulse.
//   VGA_clk  in  clock
//   reset    in  synchronous, active-high
//   btn_n    in  raw button, active-low, asynchronous
//   level    out debounced level, 1 = pressed
//   press    out 1-cycle pulse when level goes released -> pressed
// Pin edge to press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic VGA_clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // sync_pipe[1] is the metastability-safe copy of the pin.
  logic [1:0]       sync_pipe;
  logic [CNT_W-1:0] cnt;
  logic             sync_pressed;

  assign sync_pressed = ~sync_pipe[1];

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      sync_pipe <= 2'b11;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn_n};
      press     <= 1'b0;
      if (cnt == CNT_MAX) begin
        // Enough consecutive disagreeing samples: accept the new level.
        level <= ~level;
        cnt   <= '0;
        press <= ~level;
      end else if (sync_pressed != level) begin
        cnt <= cnt + 1'b1;
      end else begin
        // Any agreeing sample restarts the stability window.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl -- direction front-end for the Snake core.
//   VGA_clk  in  system clock
//   reset    in  synchronous, active-high
//   btn_n    in  [3:0] raw buttons, active-low {E,S,W,N}
//   update   in  single-cycle move tick from the core
//   dir_n    out [3:0] committed heading, one-cold; 4'b1111 = stopped
//   moving   out high when dir_n != 4'b1111
// Each button is debounced into a press pulse; the lowest-index pulse wins,
// is filtered against the reference heading and parked in a pending
// register, which commits to dir_n only on update (one turn per step).
// Build option: define DIR_REVERSE_BLOCK_EN to drop requests for the
// direct opposite of the reference heading.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic [3:0] btn_n,
  input  logic       update,
  output logic [3:0] dir_n,
  output logic       moving
);

`ifdef DIR_REVERSE_BLOCK_EN
  localparam bit REV_BLOCK = 1'b1;
`else
  localparam bit REV_BLOCK = 1'b0;
`endif

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] press_q;

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_db (
        .VGA_clk(VGA_clk),
        .reset  (reset),
        .btn_n  (btn_n[g]),
        .level  (level[g]),
        .press  (press[g])
      );
    end
  endgenerate

  // press only rises together with level; qualifying keeps a stray pulse
  // on a released button from ever reaching the arbiter.
  assign press_q = press & level;

  dir_req_t   req;
  dir_state_t state;
  dir_t       pend;
  logic       pend_vld;
  logic       commit;
  dir_t       ref_dir;
  logic       rev_hit;
  logic       accept;

  // Fixed priority: iterate high to low so the lowest index is written last.
  always_comb begin
    req = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press_q[i]) begin
        req.vld  = 1'b1;
        req.code = dir_from_index(2'(i));
      end
    end
  end

  assign commit  = update & pend_vld;
  // On a commit cycle the pending heading is what dir_n is about to become,
  // so new requests are judged against it.
  assign ref_dir = commit ? pend : dir_n;
  assign rev_hit = REV_BLOCK && (req.code == dir_opposite(ref_dir));
  assign accept  = req.vld &&
                   ((ref_dir == DIR_STOP) || ((req.code != ref_dir) && !rev_hit));

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state    <= ST_STOPPED;
      dir_n    <= DIR_STOP;
      moving   <= 1'b0;
      pend     <= DIR_STOP;
      pend_vld <= 1'b0;
    end else begin
      if (accept) pend <= req.code;
      // Last accepted press wins; a commit consumes pending unless a new
      // request lands in the same cycle.
      pend_vld <= accept | (pend_vld & ~update);
      case (state)
        ST_STOPPED: begin
          if (commit) begin
            state  <= ST_MOVING;
            dir_n  <= pend;
            moving <= (pend != DIR_STOP);
          end
        end
        ST_MOVING: begin
          if (commit) begin
            dir_n  <= pend;
            moving <= (pend != DIR_STOP);
          end
        end
        default: begin
          state <= ST_STOPPED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Testbench for snake_dir_ctrl with DEBOUNCE_CYCLES=4. A reference model
// tracks pin history, debounced levels, pending request and heading, and is
// compared against dir_n, moving and the internal press pulses every cycle.
module tb_snake_dir_ctrl;

  localparam int D = 4;
`ifdef DIR_REVERSE_BLOCK_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       VGA_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] btn_n   = 4'hF;
  logic       update  = 1'b0;
  logic [3:0] dir_n;
  logic       moving;

  int checks = 0;
  int errors = 0;

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) u_dut (
    .VGA_clk(VGA_clk),
    .reset  (reset),
    .btn_n  (btn_n),
    .update (update),
    .dir_n  (dir_n),
    .moving (moving)
  );

  always #5 VGA_clk = ~VGA_clk;

  // Model state. Headings are indices 0..3 = N,W,S,E; -1 = stopped.
  logic [3:0] hist[$];
  bit   [3:0] m_lvl;
  bit   [3:0] m_press;
  int         m_head = -1;
  int         m_pend = -1;
  bit         m_pv   = 1'b0;

  function automatic logic [3:0] code_of(input int h);
    logic [3:0] one;
    one = 4'b0001;
    if (h < 0) return 4'hF;
    return ~(one << h);
  endfunction

  // Advance the model over one clock edge using the inputs just sampled.
  task automatic model_edge();
    int req;
    int refh;
    bit acc;
    bit all_diff;
    int k;
    if (reset) begin
      m_head = -1; m_pend = -1; m_pv = 1'b0;
      m_press = '0; m_lvl = '0;
      hist.push_back(4'hF);
      // Reset discards whatever the synchronizers had seen.
      for (int j = hist.size() - D - 3; j < hist.size(); j++) hist[j] = 4'hF;
      return;
    end
    req = -1;
    for (int i = 3; i >= 0; i--) if (m_press[i]) req = i;
    refh = (update && m_pv) ? m_pend : m_head;
    acc  = (req >= 0) &&
           ((refh < 0) || ((req != refh) && !(REV && req == (refh + 2) % 4)));
    if (update && m_pv) m_head = m_pend;
    m_pv = acc || (m_pv && !update);
    if (acc) m_pend = req;
    // A level flips once D consecutive synchronized samples (two cycles of
    // synchronizer lag, one of register) disagree with it.
    hist.push_back(btn_n);
    k = hist.size() - 1;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int j = k - D - 2; j <= k - 3; j++)
        if (bit'(!hist[j][i]) == m_lvl[i]) all_diff = 1'b0;
      m_press[i] = 1'b0;
      if (all_diff) begin
        m_lvl[i]   = !m_lvl[i];
        m_press[i] = m_lvl[i];
      end
    end
  endtask

  task automatic step(input logic [3:0] b, input logic u, input logic r);
    @(negedge VGA_clk);
    btn_n = b; update = u; reset = r;
    @(posedge VGA_clk);
    model_edge();
    #1;
    checks++;
    if (dir_n !== code_of(m_head)) begin
      errors++;
      $display("FAIL dir_n: got %b expected %b at %0t", dir_n, code_of(m_head), $time);
    end
    checks++;
    if (moving !== (m_head >= 0)) begin
      errors++;
      $display("FAIL moving: got %b expected %b at %0t", moving, (m_head >= 0), $time);
    end
    checks++;
    if (u_dut.press !== 4'(m_press)) begin
      errors++;
      $display("FAIL press: got %b expected %b at %0t", u_dut.press, m_press, $time);
    end
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0, 1'b0);
  endtask

  task automatic press_btn(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    hold(~(one << idx), 10);
    hold(4'hF, 12);
  endtask

  task automatic do_update();
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b0, 1'b0);
  endtask

  task automatic check_dir(input string name, input logic [3:0] exp_dir);
    checks++;
    if (dir_n !== exp_dir) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, dir_n, exp_dir);
    end
    checks++;
    if (moving !== (exp_dir != 4'hF)) begin
      errors++;
      $display("FAIL %s_moving: got %b expected %b", name, moving, (exp_dir != 4'hF));
    end
  endtask

  task automatic test_reset();
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++)
      step(4'hF, (i == 20 || i == 50 || i == 80), 1'b0);
    check_dir("reset_idle", 4'b1111);
  endtask

  task automatic test_clean_press();
    for (int n = 1; n <= 10; n++) begin
      step(4'b0111, 1'b0, 1'b0);
      if (n == 6 || n == 7) begin
        checks++;
        if (u_dut.press[3] !== (n == 7)) begin
          errors++;
          $display("FAIL press_latency: cycle %0d got %b expected %b", n, u_dut.press[3], (n == 7));
        end
      end
    end
    hold(4'hF, 12);
    check_dir("clean_before_update", 4'b1111);
    step(4'hF, 1'b1, 1'b0);
    check_dir("clean_update_cycle", 4'b0111);
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step(((c / 2) % 2 == 0) ? 4'b1110 : 4'b1111, 1'b0, 1'b0);
      if (u_dut.press[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL bounce_no_pulse: got %0d expected 0", pulses);
    end
    for (int c = 0; c < 12; c++) begin
      step(4'b1110, 1'b0, 1'b0);
      if (u_dut.press[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_one_pulse: got %0d expected 1", pulses);
    end
    hold(4'hF, 12);
    do_update();
    check_dir("bounce_north", 4'b1110);
  endtask

  task automatic test_reverse();
    press_btn(3);
    do_update();
    check_dir("rev_setup_east", 4'b0111);
    press_btn(1);
    do_update();
`ifdef DIR_REVERSE_BLOCK_EN
    check_dir("rev_west_blocked", 4'b0111);
`else
    check_dir("rev_west_taken", 4'b1101);
`endif
  endtask

  task automatic test_last_wins();
    if (m_head != 3) begin
      press_btn(3);
      do_update();
    end
    check_dir("last_setup_east", 4'b0111);
    press_btn(0);
    press_btn(2);
    do_update();
    check_dir("last_wins_south", 4'b1011);
    do_update();
    check_dir("last_no_press", 4'b1011);
  endtask

  task automatic test_simul_reset();
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0);
    check_dir("simul_after_reset", 4'b1111);
    hold(4'b1010, 10);
    hold(4'hF, 12);
    do_update();
    check_dir("simul_north_wins", 4'b1110);
    press_btn(3);
    step(4'hF, 1'b0, 1'b1);
    do_update();
    check_dir("reset_drops_pending", 4'b1111);
  endtask

  task automatic test_random();
    logic [3:0] b;
    int len;
    for (int s = 0; s < 40; s++) begin
      b   = 4'($urandom_range(0, 15));
      len = $urandom_range(12, 24);
      for (int i = 0; i < len; i++) step(b, ($urandom_range(0, 4) == 0), 1'b0);
    end
    hold(4'hF, 12);
  endtask

  initial begin
    for (int i = 0; i < D + 3; i++) hist.push_back(4'hF);
    m_lvl   = '0;
    m_press = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_reverse();
    test_last_wins();
    test_simul_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
